// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - one-at-a-time command/response driver for a registered ALU
// Each accepted command gets a one-cycle EN pulse; a watchdog turns a missing OUT_VALID into an error response.
module alu_cmd_sequencer #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int FUN_WIDTH  = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [OPER_WIDTH-1:0] CMD_A,
  input  logic [OPER_WIDTH-1:0] CMD_B,
  input  logic [FUN_WIDTH-1:0]  CMD_FUN,
  input  logic [TAG_WIDTH-1:0]  CMD_TAG,
  output logic [OPER_WIDTH-1:0] ALU_A,
  output logic [OPER_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [OUT_WIDTH-1:0]  RSP_DATA,
  output logic [TAG_WIDTH-1:0]  RSP_TAG,
  output logic                  RSP_ERR,
  output logic [15:0]           OP_COUNT
);

  localparam int WD_WIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [OPER_WIDTH-1:0] a_q, b_q;
  logic [FUN_WIDTH-1:0]  fun_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [OUT_WIDTH-1:0]  rsp_data_q;
  logic                  rsp_err_q;
  logic                  cmd_ready_q;
  logic [15:0]           op_count_q;
  logic [WD_WIDTH-1:0]   wdog_q;
  logic                  cmd_fire;
  logic                  rsp_fire;
  logic                  wdog_expire;

  assign cmd_fire    = (state == IDLE) && CMD_VALID && cmd_ready_q;
  assign rsp_fire    = (state == RESP) && RSP_READY;
  assign wdog_expire = (wdog_q == WD_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Valid is checked before the watchdog so a result on the expiring edge still wins.
  always_comb begin
    state_nxt = state;
    ALU_EN    = 1'b0;
    RSP_VALID = 1'b0;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = ISSUE;
      ISSUE: begin
        ALU_EN    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (ALU_OUT_VALID || wdog_expire) state_nxt = RESP;
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CMD_READY is registered so it stays low during reset and rises one edge after release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      tag_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      op_count_q  <= '0;
      wdog_q      <= '0;
    end else begin
      cmd_ready_q <= (state_nxt == IDLE);
      if (cmd_fire) begin
        a_q   <= CMD_A;
        b_q   <= CMD_B;
        fun_q <= CMD_FUN;
        tag_q <= CMD_TAG;
      end
      if (state == ISSUE) begin
        wdog_q <= '0;
      end else if (state == WAIT && !ALU_OUT_VALID) begin
        wdog_q <= wdog_q + WD_WIDTH'(1);
      end
      if (state == WAIT) begin
        if (ALU_OUT_VALID) begin
          rsp_data_q <= ALU_OUT;
          rsp_err_q  <= 1'b0;
        end else if (wdog_expire) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
      if (rsp_fire) begin
        op_count_q <= op_count_q + 16'd1;
      end
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_FUN   = fun_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_TAG   = tag_q;
  assign RSP_ERR   = rsp_err_q;
  assign OP_COUNT  = op_count_q;

endmodule
